debug_sequencer: RTL and testbench
==================================

Name: debug_sequencer

Overview:
- Command sequencer between the UART Rx/Tx pair and the MIPS core.
- Decodes single-byte commands from the receiver and gates the core clock-enable (run, halt, single-step).
- Streams the current PC_Plus_1 back to the host through the transmitter, byte by byte, with a tx_start/tx_done handshake.
- Clocked with the core; receives baud-domain pulses already synchronous to clk.

Parameters:
- PC_W, 10, width of pc_plus_1 (1..16).
- CMD_RUN, 8'h63 ('c'), start continuous execution.
- CMD_HALT, 8'h68 ('h'), stop execution and report.
- CMD_STEP, 8'h73 ('s'), execute one instruction and report.
- CMD_REPORT, 8'h72 ('r'), report without executing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from receiver; valid when rx_done=1.
- rx_done  in  1  one-cycle pulse, new byte available.
- tx_done  in  1  one-cycle pulse, transmitter finished current byte.
- pc_plus_1  in  PC_W  core PC+1, sampled at report start.
- enable  out  1  core clock-enable.
- tx_data  out  8  byte to transmitter; stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse launching a transmission.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, enable=0, tx_start=0, tx_data=8'h00, busy=0, byte index=0, snapshot=0. Takes effect mid-transmission; transmitter is not aborted, and its later tx_done is ignored in IDLE.
- States: IDLE, RUN, STEP, LOAD, SEND, WAIT.
- IDLE, on rx_done:
  - CMD_RUN -> RUN, with enable=1 from the next cycle.
  - CMD_STEP -> STEP.
  - CMD_REPORT -> LOAD.
  - CMD_HALT or any other byte: ignored, stay IDLE.
- RUN: enable=1 every cycle.
  - rx_done with CMD_HALT -> LOAD, enable=0 from the next cycle.
  - Any other byte in RUN is dropped.
- STEP: enable=1 for exactly one clk, then -> LOAD.
- LOAD:
  - On entry, snapshot pc_plus_1 into a 16-bit register, zero-extended.
  - byte index = 0.
  - tx_data = snapshot[15:8]; single-cycle tx_start pulse; -> WAIT.
- WAIT: hold tx_data.
  - On tx_done with last byte sent -> IDLE.
  - On tx_done otherwise: increment index -> SEND.
- SEND: tx_data = next byte (snapshot[7:0] for index 1); pulse tx_start; -> WAIT.
- Frame: two bytes, MSB first: {zero-pad, pc[PC_W-1:8]} then pc[7:0].
- Latency:
  - rx_done to first tx_start = 1 cycle (REPORT), 2 cycles (STEP/HALT).
  - tx_done to next tx_start = 1 cycle.
- rx_done in STEP/LOAD/SEND/WAIT is dropped; no queueing.
- rx_done and tx_done in the same cycle in WAIT: tx_done is processed, rx_done is dropped.
- tx_done outside WAIT is ignored.
- tx_start is never asserted while waiting for tx_done (at most one byte in flight).

Optional Feature:
- Macro DEBUG_SEQ_CYCLE_COUNT_EN.
- When defined:
  - 16-bit counter increments every cycle enable=1, wrapping 16'hFFFF->0.
  - Cleared by reset and on CMD_RUN/CMD_STEP acceptance in IDLE (cleared before counting).
  - Counter is snapshotted in LOAD alongside the PC.
  - Frame is 4 bytes: pc_hi, pc_lo, cnt[15:8], cnt[7:0].
- When undefined: no counter logic; frame is 2 bytes.

Decomposition:
- Package debug_pkg holds:
  - state encoding constants.
  - command codes (CMD_* defaults).
  - FRAME_BYTES (2, or 4 with the macro).
- One natural sub-module: debug_tx_serializer (LOAD/SEND/WAIT byte walker with index counter and handshake), fed by the command FSM with a start pulse and snapshot word.

Test Plan:
- Reset mid-WAIT: assert rst_n=0 during WAIT -> enable=0, tx_start=0, state IDLE; a following stray tx_done produces no tx_start.
- pc_plus_1=10'h2A5, send 'r' -> tx_start pulses carry 8'h02 then 8'hA5; each second pulse occurs 1 cycle after the first tx_done; busy falls after the second tx_done.
- Send 's' with pc_plus_1=10'h011 -> enable high for exactly 1 cycle, then frame 8'h00, 8'h11.
- Send 'c', wait 50 cycles, send 'x' (dropped, enable stays 1), send 'h' -> enable=0 next cycle; frame reports the current pc. With DEBUG_SEQ_CYCLE_COUNT_EN, cnt bytes are the exact enable-high count.
- During WAIT, inject rx_done='c' in the same cycle as tx_done -> byte dropped; enable stays 0; frame completes normally.
- Unknown byte 8'hFF and 'h' in IDLE -> no state change, no tx_start, busy=0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared encodings, command codes and report-frame sizing for debug_sequencer.
// DEBUG_SEQ_CYCLE_COUNT_EN widens the frame from 2 to 4 bytes (PC + cycle count).
package debug_pkg;

    localparam logic [7:0] CMD_RUN_DEF    = 8'h63;  // 'c'
    localparam logic [7:0] CMD_HALT_DEF   = 8'h68;  // 'h'
    localparam logic [7:0] CMD_STEP_DEF   = 8'h73;  // 's'
    localparam logic [7:0] CMD_REPORT_DEF = 8'h72;  // 'r'

`ifdef DEBUG_SEQ_CYCLE_COUNT_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 2;
`endif
    localparam int SNAP_W = 8 * FRAME_BYTES;
    localparam int IDX_W  = $clog2(FRAME_BYTES);

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_STEP,
        SEQ_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LOAD,
        SER_SEND,
        SER_WAIT
    } ser_state_t;

    // Byte idx of the snapshot word, MSB byte first.
    function automatic logic [7:0] frame_byte(input logic [SNAP_W-1:0] word,
                                              input logic [IDX_W-1:0]  idx);
        return word[SNAP_W - 8 - 8 * int'(idx) +: 8];
    endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Byte walker for the report frame: latches a snapshot word on i_start and
// sends it MSB byte first, one byte per tx_start/tx_done handshake.
module debug_tx_serializer
    import debug_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [SNAP_W-1:0] i_word,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic              o_busy
);

    ser_state_t        r_state;
    ser_state_t        w_next;
    logic [SNAP_W-1:0] r_snap;
    logic [IDX_W-1:0]  r_idx;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic              w_last;

    assign w_last = (r_idx == IDX_W'(FRAME_BYTES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            SER_IDLE: if (i_start) w_next = SER_LOAD;
            SER_LOAD: w_next = SER_WAIT;
            SER_SEND: w_next = SER_WAIT;
            SER_WAIT: if (i_tx_done) w_next = w_last ? SER_IDLE : SER_SEND;
            default:  w_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SER_IDLE;
        else        r_state <= w_next;
    end

    // Outputs are registered so the byte and its start pulse appear together
    // in the LOAD/SEND cycle and the byte holds through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap     <= '0;
            r_idx      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= (w_next == SER_LOAD) || (w_next == SER_SEND);
            if (r_state == SER_IDLE && i_start) begin
                r_snap    <= i_word;
                r_idx     <= '0;
                r_tx_data <= frame_byte(i_word, '0);
            end else if (r_state == SER_WAIT && i_tx_done && !w_last) begin
                r_idx     <= r_idx + 1'b1;
                r_tx_data <= frame_byte(r_snap, r_idx + 1'b1);
            end
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = (r_state != SER_IDLE);

endmodule

// File: rtl/debug_sequencer.sv
// Host command sequencer: gates the core enable (run/halt/step) and reports PC+1
// over the UART Tx. DEBUG_SEQ_CYCLE_COUNT_EN adds an enabled-cycle counter to the report.
module debug_sequencer
    import debug_pkg::*;
#(
    parameter int         PC_W       = 10,
    parameter logic [7:0] CMD_RUN    = CMD_RUN_DEF,
    parameter logic [7:0] CMD_HALT   = CMD_HALT_DEF,
    parameter logic [7:0] CMD_STEP   = CMD_STEP_DEF,
    parameter logic [7:0] CMD_REPORT = CMD_REPORT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    input  logic            tx_done,
    input  logic [PC_W-1:0] pc_plus_1,
    output logic            enable,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    output logic            busy
);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic              w_enable;
    logic              w_start;
    logic              w_ser_busy;
    logic [15:0]       w_pc_ext;
    logic [SNAP_W-1:0] w_word;

    assign w_pc_ext = 16'(pc_plus_1);

    // Commands are only accepted when both the FSM and the serializer are idle.
    // HALT takes one extra cycle with enable low so HALT and STEP share the
    // same 2-cycle report latency.
    always_comb begin
        w_next   = r_state;
        w_enable = 1'b0;
        w_start  = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (rx_done && !w_ser_busy) begin
                    if (rx_data == CMD_RUN)         w_next  = SEQ_RUN;
                    else if (rx_data == CMD_STEP)   w_next  = SEQ_STEP;
                    else if (rx_data == CMD_REPORT) w_start = 1'b1;
                end
            end
            SEQ_RUN: begin
                w_enable = 1'b1;
                if (rx_done && rx_data == CMD_HALT) w_next = SEQ_HALT;
            end
            SEQ_STEP: begin
                w_enable = 1'b1;
                w_start  = 1'b1;
                w_next   = SEQ_IDLE;
            end
            SEQ_HALT: begin
                w_start = 1'b1;
                w_next  = SEQ_IDLE;
            end
            default: w_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SEQ_IDLE;
        else        r_state <= w_next;
    end

`ifdef DEBUG_SEQ_CYCLE_COUNT_EN
    logic [15:0] r_cnt;
    logic        w_clr_cnt;

    assign w_clr_cnt = (r_state == SEQ_IDLE) &&
                       ((w_next == SEQ_RUN) || (w_next == SEQ_STEP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_cnt <= 16'h0000;
        else if (w_clr_cnt) r_cnt <= 16'h0000;
        else if (w_enable)  r_cnt <= r_cnt + 16'd1;
    end

    // Count the current cycle too, so a STEP snapshot reports 1.
    assign w_word = {w_pc_ext, r_cnt + {15'd0, w_enable}};
`else
    assign w_word = w_pc_ext;
`endif

    debug_tx_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_word     (w_word),
        .i_tx_done  (tx_done),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_busy     (w_ser_busy)
    );

    assign enable = w_enable;
    assign busy   = (r_state != SEQ_IDLE) || w_ser_busy;

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: behavioural model with a per-cycle compare plus
// directed literal checks; honours DEBUG_SEQ_CYCLE_COUNT_EN for frame length.
module tb_debug_sequencer;

    localparam int PC_W = 10;
`ifdef DEBUG_SEQ_CYCLE_COUNT_EN
    localparam int NB = 4;
`else
    localparam int NB = 2;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_done = 1'b0;
    logic            tx_done = 1'b0;
    logic [PC_W-1:0] pc_plus_1 = '0;
    logic            enable;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            busy;

    debug_sequencer #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_done   (tx_done),
        .pc_plus_1 (pc_plus_1),
        .enable    (enable),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(posedge clk) cyc_n++;

    // Reference model: a mode, a pending byte queue and an in-flight flag.
    int          mode = M_IDLE;
    bit          reporting = 0;
    bit          in_flight = 0;
    bit          exp_start = 0;
    logic [7:0]  exp_data = 8'h00;
    logic [15:0] mcnt = 16'h0;
    logic [7:0]  q[$];
    bit          was_start, rep_now, en_now;
    logic [15:0] cnow;

    function automatic void launch(input logic [PC_W-1:0] pc, input logic [15:0] c);
        logic [15:0] p;
        p = 16'(pc);
        q.delete();
        q.push_back(p[15:8]);
        q.push_back(p[7:0]);
`ifdef DEBUG_SEQ_CYCLE_COUNT_EN
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
`endif
        exp_data  = q.pop_front();
        exp_start = 1;
        reporting = 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = M_IDLE; reporting = 0; in_flight = 0; exp_start = 0;
            exp_data = 8'h00; mcnt = 16'h0; q.delete();
        end else begin
            was_start = exp_start;
            rep_now   = reporting;
            en_now    = (mode == M_RUN) || (mode == M_STEP);
            cnow      = mcnt + (en_now ? 16'd1 : 16'd0);
            mcnt      = cnow;
            exp_start = 0;
            if (was_start) in_flight = 1;
            else if (in_flight && tx_done) begin
                in_flight = 0;
                if (q.size() > 0) begin exp_data = q.pop_front(); exp_start = 1; end
                else reporting = 0;
            end
            case (mode)
                M_IDLE: if (rx_done && !rep_now) begin
                    if (rx_data == 8'h63)      begin mode = M_RUN;  mcnt = 16'h0; end
                    else if (rx_data == 8'h73) begin mode = M_STEP; mcnt = 16'h0; end
                    else if (rx_data == 8'h72) launch(pc_plus_1, cnow);
                end
                M_RUN:  if (rx_done && rx_data == 8'h68) mode = M_HALT;
                M_STEP: begin launch(pc_plus_1, cnow); mode = M_IDLE; end
                M_HALT: begin launch(pc_plus_1, cnow); mode = M_IDLE; end
                default: mode = M_IDLE;
            endcase
        end
    end

    // Per-cycle compare and observation log.
    int         en_cnt = 0;
    logic [7:0] seen_d[$];
    int         seen_c[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("enable",   {31'd0, enable},   {31'd0, (mode == M_RUN) || (mode == M_STEP)});
            chk("tx_start", {31'd0, tx_start}, {31'd0, exp_start});
            chk("tx_data",  {24'd0, tx_data},  {24'd0, exp_data});
            chk("busy",     {31'd0, busy},     {31'd0, (mode != M_IDLE) || reporting});
        end
        if (enable) en_cnt++;
        if (tx_start) begin seen_d.push_back(tx_data); seen_c.push_back(cyc_n); end
    end

    // Stimulus and transmitter stand-in.
    int         xmit_cnt = 0;
    int         xmit_fix = 0;
    bit         inj_pend = 0;
    logic [7:0] inj_data = 8'h00;
    int         rx_cyc = 0;
    int         done_c[$];

    task automatic cyc(input bit rv, input logic [7:0] d, input bit stray);
        @(negedge clk);
        rx_done = rv;
        rx_data = d;
        tx_done = 1'b0;
        if (xmit_cnt > 0) begin
            xmit_cnt--;
            if (xmit_cnt == 0) begin
                tx_done = 1'b1;
                done_c.push_back(cyc_n);
                if (inj_pend) begin rx_done = 1'b1; rx_data = inj_data; inj_pend = 0; end
            end
        end
        if (stray) tx_done = 1'b1;
        if (tx_start) xmit_cnt = (xmit_fix != 0) ? xmit_fix : int'($urandom_range(1, 5));
        if (rx_done) rx_cyc = cyc_n;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            cyc(1'b0, 8'h00, 1'b0);
            k++;
        end while ((busy || xmit_cnt != 0) && k < 300);
        if (k >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", k);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int eb, sb, db, rc;
        bit rv, st;
        logic [7:0] d;
        logic [7:0] tbl[8];
        tbl = '{8'h63, 8'h68, 8'h73, 8'h72, 8'h78, 8'hFF, 8'h00, 8'h68};

        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("rst_enable",   {31'd0, enable},   0);
        chk("rst_tx_start", {31'd0, tx_start}, 0);
        chk("rst_tx_data",  {24'd0, tx_data},  0);
        chk("rst_busy",     {31'd0, busy},     0);
        rst_n = 1'b1;
        idle(3);

        // Ignored bytes in IDLE
        eb = en_cnt; sb = seen_d.size();
        cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b1, 8'h68, 1'b0);
        idle(6);
        chk("idle_ign_start", seen_d.size() - sb, 0);
        chk("idle_ign_en", en_cnt - eb, 0);
        chk("idle_ign_busy", {31'd0, busy}, 0);

        // Report
        pc_plus_1 = 10'h2A5;
        sb = seen_d.size(); db = done_c.size();
        cyc(1'b1, 8'h72, 1'b0);
        rc = rx_cyc;
        wait_idle();
        chk("rep_nbytes", seen_d.size() - sb, NB);
        if (seen_d.size() >= sb + 2 && done_c.size() > db) begin
            chk("rep_b0", {24'd0, seen_d[sb]},   32'h02);
            chk("rep_b1", {24'd0, seen_d[sb+1]}, 32'hA5);
            chk("rep_lat", seen_c[sb] - rc, 1);
            chk("rep_gap", seen_c[sb+1] - done_c[db], 1);
        end

        // Single step
        pc_plus_1 = 10'h011;
        eb = en_cnt; sb = seen_d.size();
        cyc(1'b1, 8'h73, 1'b0);
        rc = rx_cyc;
        wait_idle();
        chk("step_en", en_cnt - eb, 1);
        chk("step_nbytes", seen_d.size() - sb, NB);
        if (seen_d.size() >= sb + NB) begin
            chk("step_b0", {24'd0, seen_d[sb]},   32'h00);
            chk("step_b1", {24'd0, seen_d[sb+1]}, 32'h11);
            chk("step_lat", seen_c[sb] - rc, 2);
`ifdef DEBUG_SEQ_CYCLE_COUNT_EN
            chk("step_c0", {24'd0, seen_d[sb+2]}, 32'h00);
            chk("step_c1", {24'd0, seen_d[sb+3]}, 32'h01);
`endif
        end

        // Run, dropped byte, halt
        pc_plus_1 = 10'h155;
        eb = en_cnt; sb = seen_d.size();
        cyc(1'b1, 8'h63, 1'b0);
        idle(50);
        cyc(1'b1, 8'h78, 1'b0);
        idle(10);
        cyc(1'b1, 8'h68, 1'b0);
        rc = rx_cyc;
        wait_idle();
        chk("run_en", en_cnt - eb, 62);
        chk("run_nbytes", seen_d.size() - sb, NB);
        if (seen_d.size() >= sb + NB) begin
            chk("halt_b0", {24'd0, seen_d[sb]},   32'h01);
            chk("halt_b1", {24'd0, seen_d[sb+1]}, 32'h55);
            chk("halt_lat", seen_c[sb] - rc, 2);
`ifdef DEBUG_SEQ_CYCLE_COUNT_EN
            chk("halt_c0", {24'd0, seen_d[sb+2]}, 32'h00);
            chk("halt_c1", {24'd0, seen_d[sb+3]}, 32'h3E);
`endif
        end

        // rx_done colliding with tx_done in WAIT
        pc_plus_1 = 10'h3FF;
        xmit_fix = 3; inj_pend = 1; inj_data = 8'h63;
        eb = en_cnt; sb = seen_d.size();
        cyc(1'b1, 8'h72, 1'b0);
        wait_idle();
        xmit_fix = 0;
        idle(4);
        chk("coll_en", en_cnt - eb, 0);
        chk("coll_nbytes", seen_d.size() - sb, NB);
        if (seen_d.size() >= sb + 2) begin
            chk("coll_b0", {24'd0, seen_d[sb]},   32'h03);
            chk("coll_b1", {24'd0, seen_d[sb+1]}, 32'hFF);
        end

        // Reset while waiting for tx_done
        pc_plus_1 = 10'h0F0;
        xmit_fix = 8;
        cyc(1'b1, 8'h72, 1'b0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_enable",   {31'd0, enable},   0);
        chk("rstw_tx_start", {31'd0, tx_start}, 0);
        chk("rstw_tx_data",  {24'd0, tx_data},  0);
        chk("rstw_busy",     {31'd0, busy},     0);
        idle(1);
        rst_n = 1'b1;
        xmit_fix = 0;
        sb = seen_d.size();
        idle(12);
        chk("rstw_stray_start", seen_d.size() - sb, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rv = ($urandom_range(0, 7) == 0);
            d  = tbl[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) d = 8'($urandom);
            st = ($urandom_range(0, 15) == 0) && (xmit_cnt == 0) && !in_flight && !exp_start;
            pc_plus_1 = PC_W'($urandom);
            cyc(rv, d, st);
        end
        cyc(1'b1, 8'h68, 1'b0);
        wait_idle();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
